// File: rtl/hack_cpu_seq.sv
// +-----------------------------------------------------------------------------+
// | Module      : hack_cpu_seq                                                  |
// | Description : Two-phase fetch/execute Hack CPU sequencer driving an         |
// |               external Hack ALU, with end-of-program loop halt detection.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module hack_cpu_seq #(
  parameter logic [14:0] RESET_VECTOR = 15'h0000,
  parameter bit          HALT_DETECT  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [14:0] instr_addr,
  input  logic [15:0] instr_data,
  input  logic [15:0] inM,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic        halt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [14:0] r_pc;
  logic        r_prev_a;

  logic [15:0] w_a_nxt;
  logic [15:0] w_d_nxt;
  logic [14:0] w_pc_nxt;
  logic        w_prev_a_nxt;

  logic        w_exec;
  logic        w_is_c;
  logic        w_c_exec;
  logic        w_a_bit;
  logic [5:0]  w_comp;
  logic [2:0]  w_dest;
  logic [2:0]  w_jump;
  logic        w_take;
  logic [14:0] w_pc_inc;
  logic [14:0] w_pc_dec;
  logic        w_halt_hit;

  assign w_exec   = (r_state == S_EXEC);
  assign w_is_c   = instr_data[15];
  assign w_c_exec = w_exec & w_is_c;
  assign w_a_bit  = instr_data[12];
  assign w_comp   = instr_data[11:6];
  assign w_dest   = instr_data[5:3];
  assign w_jump   = instr_data[2:0];

  assign w_take   = w_c_exec & ((w_jump[2] & alu_ng) |
                                (w_jump[1] & alu_zr) |
                                (w_jump[0] & ~alu_ng & ~alu_zr));
  assign w_pc_inc = r_pc + 15'd1;
  assign w_pc_dec = r_pc - 15'd1;

  // @END; 0;JMP idiom: an A-load of our own address followed by a taken jump back to it
  generate
    if (HALT_DETECT) begin : g_halt_on
      assign w_halt_hit = w_take & r_prev_a & (r_a[14:0] == w_pc_dec);
    end else begin : g_halt_off
      assign w_halt_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_d_nxt      = r_d;
    w_pc_nxt     = r_pc;
    w_prev_a_nxt = r_prev_a;
    case (r_state)
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (!w_is_c) begin
          w_a_nxt      = {1'b0, instr_data[14:0]};
          w_pc_nxt     = w_pc_inc;
          w_prev_a_nxt = 1'b1;
          w_state_nxt  = S_FETCH;
        end else begin
          if (w_dest[2]) w_a_nxt = alu_out;
          if (w_dest[1]) w_d_nxt = alu_out;
          // jump target is the pre-update A, even when dest includes A
          w_pc_nxt     = w_take ? r_a[14:0] : w_pc_inc;
          w_prev_a_nxt = 1'b0;
          w_state_nxt  = w_halt_hit ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_a      <= 16'h0000;
      r_d      <= 16'h0000;
      r_pc     <= RESET_VECTOR;
      r_prev_a <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_d      <= w_d_nxt;
      r_pc     <= w_pc_nxt;
      r_prev_a <= w_prev_a_nxt;
    end
  end

  assign instr_addr = r_pc;
  assign addressM   = r_a[14:0];
  assign outM       = alu_out;
  assign writeM     = w_c_exec & w_dest[0];
  assign alu_x      = r_d;
  assign alu_y      = (w_c_exec & w_a_bit) ? inM : r_a;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = w_c_exec ? w_comp : 6'b000000;
  assign halt       = (r_state == S_HALT);

endmodule

`default_nettype wire
